pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
Central stall/flush scheduler for the 5-stage core. Produces the per-register stall vector and flush pulse consumed by every PipelineDeliver-based stage register (PC, IFID, IDEX, EXMEM, MEMWB). Arbitrates stage stall requests, RAM wait, and MEM-stage exceptions/ERET. Issues the redirect PC to the PC register on exception entry or return.

Parameters:
EXC_ENTRY, 32'hBFC0_0380, exception handler entry address.
WDOG_LIMIT, 16'd1023, consecutive ram_busy cycles before timeout (used only with the optional feature).

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset (0 = reset)
stall_req_if  in  1  IF stage waiting on instruction fetch
stall_req_id  in  1  ID load-use hazard
stall_req_ex  in  1  EX multi-cycle mult/div busy
stall_req_mem  in  1  MEM stage waiting on RAM
ram_busy  in  1  data RAM transaction outstanding
exc_valid  in  1  MEM stage reports an exception or ERET
exc_type  in  `EXC_TYPE_BUS  exception code (`EXC_ERET selects return)
epc_in  in  `ADDR_BUS  CP0 EPC value
stall  out  5  bit0 = PC, bit1 = IFID, bit2 = IDEX, bit3 = EXMEM, bit4 = MEMWB
flush  out  1  one-cycle flush of all stage registers
pc_load  out  1  PC register loads exc_pc this cycle
exc_pc  out  `ADDR_BUS  redirect target
wdog_timeout  out  1  sticky RAM timeout flag

Behaviour:
- Reset (rst = 0, async): state RUN. stall = 0, flush = 0, pc_load = 0, exc_pc = 0, wdog_timeout = 0, captured exception cleared.
- Stall vector in RUN is combinational, same cycle:
  - stall_req_mem -> 5'b01111
  - else stall_req_ex -> 5'b00111
  - else stall_req_id -> 5'b00011
  - else stall_req_if -> 5'b00001
  - else 0.
  - Highest requesting stage wins. Each stage register's stall_next_stage is the next bit, and MEMWB's is 0, so the register just after the stalled region receives a bubble.
- FSM states: RUN, FLUSH_PEND, FLUSH.
- RUN -> FLUSH on exc_valid & !ram_busy. exc_pc is registered at that edge:
  - exc_type == `EXC_ERET -> epc_in
  - otherwise -> EXC_ENTRY.
- RUN -> FLUSH_PEND on exc_valid & ram_busy:
  - exc_type and epc_in are captured at entry.
  - stall = 5'b11111 while pending; flush = 0.
  - Leaves to FLUSH the cycle after ram_busy drops.
- FLUSH: single cycle. flush = 1, pc_load = 1, stall = 0, exc_pc valid. Always returns to RUN. exc_valid arriving during FLUSH is ignored because it comes from a flushed instruction.
- Priority: flush > stall. exc_valid in RUN overrides stall requests for the state decision; the stall vector still follows the requests that cycle.
- exc_pc holds its value after FLUSH until the next capture. pc_load is 1 only in FLUSH.
- Reset mid-FLUSH_PEND or mid-FLUSH: the pending exception is dropped with no flush pulse.
- Total latency from exc_valid (RAM idle) to flush: 1 cycle.

Optional Feature:
Macro PIPE_CTRL_WATCHDOG_EN.
- Defined:
  - A 16-bit counter increments on each cycle ram_busy = 1 and clears when ram_busy = 0.
  - When the counter equals WDOG_LIMIT: wdog_timeout sets (sticky until reset), FSM goes to FLUSH with exc_pc = EXC_ENTRY, even from FLUSH_PEND, and the counter clears.
  - In the flush cycle the RAM side must abandon its transaction.
- Undefined: no counter is built; wdog_timeout is tied to 0; FLUSH_PEND waits on ram_busy indefinitely.

Decomposition:
- bus.v (shared include) owns `EXC_TYPE_BUS, the `EXC_* codes including `EXC_ERET, `ADDR_BUS, and the stall-vector width constant `STALL_BUS.
- FSM state encodings are local parameters.
- One natural sub-module: pipeline_ctrl_wdog, holding the counter and sticky flag, instantiated only under the macro.

Test Plan:
- stall_req_id = 1 and stall_req_ex = 1 together -> stall = 5'b00111. Drop stall_req_ex -> stall = 5'b00011 the same cycle.
- exc_valid = 1, exc_type = overflow, ram_busy = 0 -> next cycle flush = 1, pc_load = 1, exc_pc = 32'hBFC00380; following cycle flush = 0.
- exc_valid ERET with epc_in = 32'h8000_1234 -> flush cycle exc_pc = 32'h80001234.
- exc_valid while ram_busy = 1 for 3 cycles -> stall = 5'b11111 for 3 cycles, then flush exactly one cycle after ram_busy falls. Changing epc_in mid-wait does not alter exc_pc.
- Assert rst = 0 during FLUSH_PEND -> all outputs 0 immediately; no flush after release.
- With PIPE_CTRL_WATCHDOG_EN and WDOG_LIMIT = 8: hold ram_busy = 1 -> wdog_timeout = 1 and flush on the 8th busy cycle. Without the macro: no flush, wdog_timeout = 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared bus widths, exception codes and stall-vector helpers for pipeline_ctrl.
// The legacy bus `defines live here so older stage files keep their names.
`ifndef PIPE_CTRL_BUS_DEFS
`define PIPE_CTRL_BUS_DEFS
`define ADDR_BUS 31:0
`define EXC_TYPE_BUS 4:0
`define STALL_BUS 4:0
`define EXC_INT 5'h00
`define EXC_ADEL 5'h04
`define EXC_ADES 5'h05
`define EXC_SYS 5'h08
`define EXC_BP 5'h09
`define EXC_RI 5'h0a
`define EXC_OV 5'h0c
`define EXC_ERET 5'h1f
`endif

package pipeline_ctrl_pkg;

   typedef logic [`ADDR_BUS]     addr_t;
   typedef logic [`EXC_TYPE_BUS] exc_type_t;
   typedef logic [`STALL_BUS]    stall_t;

   localparam exc_type_t EXC_INT  = `EXC_INT;
   localparam exc_type_t EXC_ADEL = `EXC_ADEL;
   localparam exc_type_t EXC_ADES = `EXC_ADES;
   localparam exc_type_t EXC_SYS  = `EXC_SYS;
   localparam exc_type_t EXC_BP   = `EXC_BP;
   localparam exc_type_t EXC_RI   = `EXC_RI;
   localparam exc_type_t EXC_OV   = `EXC_OV;
   localparam exc_type_t EXC_ERET = `EXC_ERET;

   // Bit n freezes stage register n; the register after the frozen run gets a bubble.
   localparam stall_t STALL_NONE = 5'b00000;
   localparam stall_t STALL_IF   = 5'b00001;
   localparam stall_t STALL_ID   = 5'b00011;
   localparam stall_t STALL_EX   = 5'b00111;
   localparam stall_t STALL_MEM  = 5'b01111;
   localparam stall_t STALL_ALL  = 5'b11111;

   function automatic stall_t req_stall(input logic req_if,
                                        input logic req_id,
                                        input logic req_ex,
                                        input logic req_mem);
      stall_t s;
      if (req_mem)
         s = STALL_MEM;
      else if (req_ex)
         s = STALL_EX;
      else if (req_id)
         s = STALL_ID;
      else if (req_if)
         s = STALL_IF;
      else
         s = STALL_NONE;
      return s;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_wdog.sv
// RAM-busy watchdog: counts consecutive busy cycles and raises a sticky timeout.
// hit pulses in the busy cycle that brings the count to LIMIT; the count then restarts.
module pipeline_ctrl_wdog #(
   parameter logic [15:0] LIMIT = 16'd1023
) (
   input  logic clk,
   input  logic rst,
   input  logic ram_busy,
   output logic hit,
   output logic timeout
);

   logic [15:0] cnt_q, cnt_d;
   logic        timeout_q, timeout_d;

   always_comb begin
      hit       = ram_busy && ((cnt_q + 16'd1) == LIMIT);
      cnt_d     = '0;
      timeout_d = timeout_q | hit;
      if (ram_busy && !hit)
         cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush scheduler for the 5-stage core (PC, IFID, IDEX, EXMEM, MEMWB).
// Optional RAM watchdog is built only when PIPE_CTRL_WATCHDOG_EN is defined.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter addr_t       EXC_ENTRY  = 32'hBFC0_0380,
   parameter logic [15:0] WDOG_LIMIT = 16'd1023
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      stall_req_if,
   input  logic      stall_req_id,
   input  logic      stall_req_ex,
   input  logic      stall_req_mem,
   input  logic      ram_busy,
   input  logic      exc_valid,
   input  exc_type_t exc_type,
   input  addr_t     epc_in,
   output stall_t    stall,
   output logic      flush,
   output logic      pc_load,
   output addr_t     exc_pc,
   output logic      wdog_timeout
);

   localparam logic [1:0] ST_RUN        = 2'd0;
   localparam logic [1:0] ST_FLUSH_PEND = 2'd1;
   localparam logic [1:0] ST_FLUSH      = 2'd2;

   logic [1:0] state_q, state_d;
   addr_t      exc_pc_q, exc_pc_d;
   exc_type_t  cap_type_q, cap_type_d;
   addr_t      cap_epc_q, cap_epc_d;
   logic       wdog_hit;

   function automatic addr_t redirect_pc(input exc_type_t t, input addr_t epc);
      return (t == EXC_ERET) ? epc : EXC_ENTRY;
   endfunction

`ifdef PIPE_CTRL_WATCHDOG_EN
   pipeline_ctrl_wdog #(
      .LIMIT (WDOG_LIMIT)
   ) u_wdog (
      .clk      (clk),
      .rst      (rst),
      .ram_busy (ram_busy),
      .hit      (wdog_hit),
      .timeout  (wdog_timeout)
   );
`else
   assign wdog_hit     = 1'b0;
   assign wdog_timeout = 1'b0 & (WDOG_LIMIT != 16'd0);
`endif

   // A pending exception holds the whole pipe until RAM goes idle, then flushes once.
   always_comb begin
      state_d    = state_q;
      exc_pc_d   = exc_pc_q;
      cap_type_d = cap_type_q;
      cap_epc_d  = cap_epc_q;
      stall      = STALL_NONE;
      flush      = 1'b0;
      pc_load    = 1'b0;

      case (state_q)
         ST_RUN: begin
            stall = req_stall(stall_req_if, stall_req_id, stall_req_ex, stall_req_mem);
            if (exc_valid) begin
               if (ram_busy) begin
                  state_d    = ST_FLUSH_PEND;
                  cap_type_d = exc_type;
                  cap_epc_d  = epc_in;
               end else begin
                  state_d  = ST_FLUSH;
                  exc_pc_d = redirect_pc(exc_type, epc_in);
               end
            end
         end
         ST_FLUSH_PEND: begin
            stall = STALL_ALL;
            if (!ram_busy) begin
               state_d  = ST_FLUSH;
               exc_pc_d = redirect_pc(cap_type_q, cap_epc_q);
            end
         end
         ST_FLUSH: begin
            flush   = 1'b1;
            pc_load = 1'b1;
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase

      // A RAM timeout abandons whatever was pending and enters the handler.
      if (wdog_hit) begin
         state_d  = ST_FLUSH;
         exc_pc_d = EXC_ENTRY;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_RUN;
         exc_pc_q   <= '0;
         cap_type_q <= '0;
         cap_epc_q  <= '0;
      end else begin
         state_q    <= state_d;
         exc_pc_q   <= exc_pc_d;
         cap_type_q <= cap_type_d;
         cap_epc_q  <= cap_epc_d;
      end
   end

   assign exc_pc = exc_pc_q;

endmodule
